gpr_write_arbiter: RTL and testbench

Shares the single write port of the 8×16-bit general-purpose register file (`gpr`) among several writeback sources: ALU result, memory load, and I/O input. Each source raises a request carrying a register index and data. The arbiter grants one source per cycle in round-robin order and drives the file's `d_in`, `write_select` and `load` from registered outputs. It sits between the execute/memory stages and `gpr`, and is the only block allowed to drive the file's write port.

---
 rtl/gpr_write_arbiter.sv | 150 +++++++++++++++
 tb/tb_gpr_write_arbiter.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/gpr_write_arbiter.sv
// gpr_write_arbiter
//   Round-robin arbiter that shares the single write port of the 8x16 gpr
//   among the writeback sources (0 = ALU, 1 = MEM, 2 = IO). One grant per
//   cycle at most. Every output comes from a register.
//
// Ports
//   clk          rising-edge clock
//   reset        asynchronous reset, active low
//   hold         high blocks any new grant
//   req          per-requester write request, held until granted
//   req_sel      requester i target register at [i*AW +: AW]
//   req_data     requester i write data at [i*DW +: DW]
//   gnt          one-hot (or zero) 1-cycle pulse accepting requester i
//   d_in         gpr write data
//   write_select gpr write index
//   load         gpr write enable
//   err          1-cycle pulse: granted request had req_sel >= NREG, dropped
//   wr_count     number of writes issued to the gpr (wraps)
module gpr_write_arbiter #(
    parameter int NREQ = 3,
    parameter int DW   = 16,
    parameter int AW   = 4,
    parameter int NREG = 8
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 hold,
    input  logic [NREQ-1:0]      req,
    input  logic [NREQ*AW-1:0]   req_sel,
    input  logic [NREQ*DW-1:0]   req_data,
    output logic [NREQ-1:0]      gnt,
    output logic [DW-1:0]        d_in,
    output logic [AW-1:0]        write_select,
    output logic                 load,
    output logic                 err,
    output logic [15:0]          wr_count
);

    localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

    typedef enum logic {IDLE = 1'b0, WRITE = 1'b1} state_t;

    state_t          state_q, state_d;
    logic [NREQ-1:0] gnt_q, gnt_d;
    logic [PW-1:0]   ptr_q, ptr_d;
    logic            err_q, err_d;
    logic [DW-1:0]   d_in_q, d_in_d;
    logic [AW-1:0]   ws_q, ws_d;
    logic [15:0]     cnt_q, cnt_d;

    // Unpack the flat request buses so the winner can be indexed directly.
    logic [AW-1:0] sel_arr  [NREQ];
    logic [DW-1:0] data_arr [NREQ];

    for (genvar i = 0; i < NREQ; i++) begin : g_unpack
        assign sel_arr[i]  = req_sel[i*AW +: AW];
        assign data_arr[i] = req_data[i*DW +: DW];
    end

    logic [NREQ-1:0] elig;
    logic            found;
    logic [PW-1:0]   win;
    logic [PW:0]     cand;
    logic            sel_ok;
    logic            wr_valid;

    // Winner search: first eligible requester starting at ptr, wrapping.
    // gnt_q doubles as last_gnt, so a requester just granted sits out one
    // cycle while it drops its request.
    always_comb begin
        elig  = req & ~gnt_q;
        found = 1'b0;
        win   = '0;
        cand  = '0;
        if (!hold) begin
            for (int off = 0; off < NREQ; off++) begin
                cand = {1'b0, ptr_q} + (PW+1)'(off);
                if (cand >= (PW+1)'(NREQ)) cand = cand - (PW+1)'(NREQ);
                if (!found && elig[cand[PW-1:0]]) begin
                    found = 1'b1;
                    win   = cand[PW-1:0];
                end
            end
        end
    end

    always_comb begin
        sel_ok   = ({1'b0, sel_arr[win]} < (AW+1)'(NREG));
        wr_valid = found && sel_ok;

        gnt_d  = '0;
        ptr_d  = ptr_q;
        err_d  = 1'b0;
        d_in_d = d_in_q;
        ws_d   = ws_q;
        cnt_d  = cnt_q;

        if (found) begin
            gnt_d[win] = 1'b1;
            ptr_d      = (win == PW'(NREQ-1)) ? '0 : win + PW'(1);
            // Out-of-range selects still retire the requester, but never
            // touch the file.
            err_d      = !sel_ok;
        end
        if (wr_valid) begin
            d_in_d = data_arr[win];
            ws_d   = sel_arr[win];
            cnt_d  = cnt_q + 16'd1;
        end
    end

    // FSM: load is the WRITE state. A back-to-back grant always goes to a
    // different requester because last_gnt masks the previous winner.
    always_comb begin
        state_d = IDLE;
        case (state_q)
            IDLE:    if (wr_valid) state_d = WRITE;
            WRITE:   if (wr_valid && (gnt_d != gnt_q)) state_d = WRITE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            gnt_q   <= '0;
            ptr_q   <= '0;
            err_q   <= 1'b0;
            d_in_q  <= '0;
            ws_q    <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            gnt_q   <= gnt_d;
            ptr_q   <= ptr_d;
            err_q   <= err_d;
            d_in_q  <= d_in_d;
            ws_q    <= ws_d;
            cnt_q   <= cnt_d;
        end
    end

    assign gnt          = gnt_q;
    assign load         = (state_q == WRITE);
    assign err          = err_q;
    assign d_in         = d_in_q;
    assign write_select = ws_q;
    assign wr_count     = cnt_q;

endmodule

// File: tb/tb_gpr_write_arbiter.sv
module tb_gpr_write_arbiter;

    localparam int NREQ = 3;
    localparam int DW   = 16;
    localparam int AW   = 4;

    logic                clk;
    logic                reset;
    logic                hold;
    logic [NREQ-1:0]     req;
    logic [NREQ*AW-1:0]  req_sel;
    logic [NREQ*DW-1:0]  req_data;
    logic [NREQ-1:0]     gnt;
    logic [DW-1:0]       d_in;
    logic [AW-1:0]       write_select;
    logic                load;
    logic                err;
    logic [15:0]         wr_count;

    gpr_write_arbiter #(.NREQ(NREQ), .DW(DW), .AW(AW), .NREG(8)) dut (
        .clk(clk), .reset(reset), .hold(hold), .req(req),
        .req_sel(req_sel), .req_data(req_data), .gnt(gnt), .d_in(d_in),
        .write_select(write_select), .load(load), .err(err),
        .wr_count(wr_count)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Reference register file fed by the arbiter's write port.
    logic [DW-1:0] gpr_m [0:7];
    always @(posedge clk) begin
        if (load === 1'b1 && write_select < 4'd8) gpr_m[write_select[2:0]] <= d_in;
    end

    typedef struct {
        logic [NREQ-1:0] gnt;
        logic            load;
        logic            err;
        logic [AW-1:0]   sel;
        logic [DW-1:0]   data;
    } exp_t;

    exp_t sbq[$];
    int   passed = 0;
    int   total  = 0;
    int   exp_wr = 0;

    task automatic set_req(input int i, input logic [AW-1:0] s, input logic [DW-1:0] d);
        req_sel[i*AW +: AW]  = s;
        req_data[i*DW +: DW] = d;
    endtask

    task automatic push(input logic [NREQ-1:0] g, input logic ld, input logic e,
                        input logic [AW-1:0] s, input logic [DW-1:0] d);
        exp_t x;
        x.gnt = g; x.load = ld; x.err = e; x.sel = s; x.data = d;
        sbq.push_back(x);
        if (ld) exp_wr++;
    endtask

    // One cycle: sample at negedge, pop the scoreboard on any grant and
    // retire the granted requester like a registered source would.
    task automatic step();
        exp_t x;
        @(negedge clk);
        if (gnt !== '0) begin
            total++;
            if (sbq.size() == 0) begin
                $display("FAIL unexpected_gnt got=%b want=none", gnt);
            end else begin
                x = sbq.pop_front();
                if ({gnt, load, err} !== {x.gnt, x.load, x.err})
                    $display("FAIL grant gnt/load/err got=%b/%b/%b want=%b/%b/%b",
                             gnt, load, err, x.gnt, x.load, x.err);
                else passed++;
                if (x.load) begin
                    total++;
                    if ({write_select, d_in} !== {x.sel, x.data})
                        $display("FAIL write sel/data got=%0d/%h want=%0d/%h",
                                 write_select, d_in, x.sel, x.data);
                    else passed++;
                end
            end
            req = req & ~gnt;
        end
    endtask

    task automatic drain(input string name);
        for (int i = 0; i < 20 && sbq.size() > 0; i++) step();
        if (sbq.size() > 0) begin
            total++;
            $display("FAIL %s timeout pending=%0d want=0", name, sbq.size());
            sbq.delete();
        end
    endtask

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
        total++;
        if (got !== want) $display("FAIL %s got=%h want=%h", name, got, want);
        else passed++;
    endtask

    task automatic do_reset();
        @(negedge clk);
        req = '0; hold = 1'b0; reset = 1'b0;
        exp_wr = 0;
        @(negedge clk);
        reset = 1'b1;
    endtask

    task automatic test_reset();
        reset = 1'b0; hold = 1'b0; req = '0; req_sel = '0; req_data = '0;
        @(negedge clk);
        @(negedge clk);
        chk("rst_gnt",  32'(gnt), 0);
        chk("rst_load", 32'(load), 0);
        chk("rst_err",  32'(err), 0);
        chk("rst_din",  32'(d_in), 0);
        chk("rst_ws",   32'(write_select), 0);
        chk("rst_cnt",  32'(wr_count), 0);
        reset = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("idle_gnt", 32'(gnt), 0);
            chk("idle_load", 32'(load), 0);
        end
    endtask

    task automatic test_single();
        set_req(0, 4'd2, 16'd23);
        req = 3'b001;
        push(3'b001, 1'b1, 1'b0, 4'd2, 16'd23);
        drain("single");
        step();
        chk("single_r2", 32'(gpr_m[2]), 23);
        chk("single_cnt", 32'(wr_count), 1);
    endtask

    task automatic test_contention();
        do_reset();
        set_req(0, 4'd6, 16'd18);
        set_req(1, 4'd0, 16'd23);
        set_req(2, 4'd3, 16'd5);
        req = 3'b111;
        push(3'b001, 1'b1, 1'b0, 4'd6, 16'd18);
        push(3'b010, 1'b1, 1'b0, 4'd0, 16'd23);
        push(3'b100, 1'b1, 1'b0, 4'd3, 16'd5);
        // Three back-to-back grants must land in exactly three cycles.
        for (int i = 0; i < 3; i++) step();
        chk("cont_b2b_pending", 32'(sbq.size()), 0);
        drain("contention");
        step();
        chk("cont_r6", 32'(gpr_m[6]), 18);
        chk("cont_r0", 32'(gpr_m[0]), 23);
        chk("cont_r3", 32'(gpr_m[3]), 5);
        chk("cont_cnt", 32'(wr_count), 32'(exp_wr));
    endtask

    task automatic test_same_reg();
        // ptr wrapped back to 0 after the contention round.
        set_req(0, 4'd4, 16'h1111);
        set_req(1, 4'd4, 16'h2222);
        req = 3'b011;
        push(3'b001, 1'b1, 1'b0, 4'd4, 16'h1111);
        push(3'b010, 1'b1, 1'b0, 4'd4, 16'h2222);
        drain("same_reg");
        step();
        chk("same_r4", 32'(gpr_m[4]), 32'h2222);
        chk("same_cnt", 32'(wr_count), 32'(exp_wr));
    endtask

    task automatic test_bad_sel();
        set_req(2, 4'd9, 16'hDEAD);
        req = 3'b100;
        push(3'b100, 1'b0, 1'b1, 4'd9, 16'hDEAD);
        drain("bad_sel");
        step();
        chk("bad_err_clear", 32'(err), 0);
        chk("bad_cnt", 32'(wr_count), 32'(exp_wr));
        chk("bad_ws_kept", 32'(write_select), 4);
    endtask

    task automatic test_hold();
        // ptr is 0 again after the grant to requester 2.
        set_req(0, 4'd1, 16'hA001);
        set_req(1, 4'd5, 16'hB005);
        hold = 1'b1;
        req  = 3'b011;
        for (int i = 0; i < 4; i++) begin
            step();
            chk("hold_gnt", 32'(gnt), 0);
        end
        hold = 1'b0;
        push(3'b001, 1'b1, 1'b0, 4'd1, 16'hA001);
        push(3'b010, 1'b1, 1'b0, 4'd5, 16'hB005);
        drain("hold_release");
        step();
        chk("hold_r1", 32'(gpr_m[1]), 32'hA001);
        chk("hold_r5", 32'(gpr_m[5]), 32'hB005);
    endtask

    task automatic test_reset_mid();
        // ptr is 2 now; only requester 0 asks so it wins.
        set_req(0, 4'd7, 16'hABCD);
        req = 3'b001;
        @(posedge clk);
        #1;
        chk("mid_gnt", 32'(gnt), 32'b001);
        chk("mid_load", 32'(load), 1);
        reset = 1'b0;
        req   = '0;
        #1;
        chk("mid_load_drop", 32'(load), 0);
        chk("mid_gnt_drop", 32'(gnt), 0);
        chk("mid_cnt", 32'(wr_count), 0);
        chk("mid_ws", 32'(write_select), 0);
        exp_wr = 0;
        @(negedge clk);
        reset = 1'b1;
        // ptr was 1 before reset; a full request must restart at requester 0.
        set_req(0, 4'd2, 16'h0102);
        set_req(1, 4'd3, 16'h0203);
        set_req(2, 4'd6, 16'h0306);
        req = 3'b111;
        push(3'b001, 1'b1, 1'b0, 4'd2, 16'h0102);
        push(3'b010, 1'b1, 1'b0, 4'd3, 16'h0203);
        push(3'b100, 1'b1, 1'b0, 4'd6, 16'h0306);
        drain("post_reset");
        step();
        chk("post_cnt", 32'(wr_count), 32'(exp_wr));
        chk("mid_r7_untouched", 32'(gpr_m[7] === 16'hABCD), 0);
    endtask

    initial begin
        for (int i = 0; i < 8; i++) gpr_m[i] = '0;
        test_reset();
        test_single();
        test_contention();
        test_same_reg();
        test_bad_sel();
        test_hold();
        test_reset_mid();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
